// File: rtl/jtcontra_obj_dma_if.sv
// ----------------------------------------------------------------------------
// jtcontra_obj_dma_if
//   Buses of the object-table DMA.
//   Source side : src_cs / src_addr out of the DMA, src_data back one clk later
//                 from the CPU object RAM.
//   Scan side   : scan_addr from the object line renderer, obj_scan back from
//                 the frozen front bank.
//   master : the DMA block.
//   slave  : CPU object RAM + object line renderer.
// ----------------------------------------------------------------------------
interface jtcontra_obj_dma_if;
    logic       src_cs;
    logic [9:0] src_addr;
    logic [7:0] src_data;
    logic [9:0] scan_addr;
    logic [7:0] obj_scan;

    modport master (
        output src_cs, src_addr, obj_scan,
        input  src_data, scan_addr
    );

    modport slave (
        input  src_cs, src_addr, obj_scan,
        output src_data, scan_addr
    );
endinterface

// File: rtl/jtcontra_obj_dma.sv
// ----------------------------------------------------------------------------
// jtcontra_obj_dma
//   Object-table DMA for the 007121 sprite path. On the falling edge of LVBL
//   (and with dma_en set) the CPU object RAM is copied into the back shadow
//   bank. When the copy completes the banks exchange, so the renderer always
//   reads a complete, frozen table and CPU writes during active video never
//   tear a frame.
//
// Ports
//   clk, rst : system clock, synchronous active-high reset
//   LVBL     : vertical blank, active low
//   dma_en   : copy enable, sampled at the LVBL falling edge
//   bus      : src_cs/src_addr/src_data (CPU object RAM read port) and
//              scan_addr/obj_scan (renderer read port, 1 clk latency)
//   busy     : copy in progress
//   swap     : one-clk pulse when the banks exchange
// ----------------------------------------------------------------------------
module jtcontra_obj_dma #(
    parameter int OBJ_BYTES = 320,
    parameter int AW        = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               LVBL,
    input  logic               dma_en,
    jtcontra_obj_dma_if.master bus,
    output logic               busy,
    output logic               swap
);

    localparam logic [9:0] LAST = 10'(OBJ_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        COPY,
        FLUSH
    } state_t;

    state_t         state, state_nx;
    logic [9:0]     rd_cnt, rd_nx;
    logic           last_LVBL;
    logic           start;
    logic           do_swap;
    logic           front;
    logic           wr_valid;
    logic [AW-1:0]  wr_addr;

    logic [7:0]     bank0 [2**AW];
    logic [7:0]     bank1 [2**AW];

    // Only the low AW bits of the renderer address select a byte.
    logic           unused_scan_msb;
    assign unused_scan_msb = bus.scan_addr[9];

    assign start        = !LVBL && last_LVBL;
    assign bus.src_cs   = (state == COPY);
    assign bus.src_addr = rd_cnt;
    assign busy         = (state != IDLE);

    always_comb begin
        // NOTE: every signal gets a default before the case so no branch can
        // leave it unassigned and infer a latch.
        state_nx = state;
        rd_nx    = rd_cnt;
        do_swap  = 1'b0;
        case (state)
            IDLE: begin
                if (start && dma_en) begin
                    state_nx = COPY;
                    rd_nx    = '0;
                end
            end
            COPY: begin
                if (LVBL) begin
                    // Vblank ended early: drop the partial copy.
                    state_nx = IDLE;
                    rd_nx    = '0;
                end else if (rd_cnt == LAST) begin
                    state_nx = FLUSH;
                    rd_nx    = '0;
                end else begin
                    rd_nx = rd_cnt + 10'd1;
                end
            end
            FLUSH: begin
                // The last byte lands in the back bank on this edge, so the
                // exchange can happen on the same edge.
                state_nx = IDLE;
                do_swap  = !LVBL;
            end
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rd_cnt    <= '0;
            last_LVBL <= 1'b1;
            front     <= 1'b0;
            swap      <= 1'b0;
            wr_valid  <= 1'b0;
            wr_addr   <= '0;
            bus.obj_scan <= '0;
        end else begin
            state     <= state_nx;
            rd_cnt    <= rd_nx;
            last_LVBL <= LVBL;
            swap      <= do_swap;
            if (do_swap) front <= ~front;
            // src_data arrives one clk after the address, so the write
            // address/strobe are delayed by the same amount.
            wr_valid  <= bus.src_cs;
            wr_addr   <= rd_cnt[AW-1:0];
            // Uses the pre-edge front: a read issued on the swap clk already
            // sees the new bank.
            bus.obj_scan <= front ? bank1[bus.scan_addr[AW-1:0]]
                                  : bank0[bus.scan_addr[AW-1:0]];
        end
    end

    // NOTE: the shadow banks are plain storage with no reset; clearing them
    // would block RAM inference and nothing depends on their initial value.
    always_ff @(posedge clk) begin
        if (wr_valid) begin
            if (front) bank0[wr_addr] <= bus.src_data;
            else       bank1[wr_addr] <= bus.src_data;
        end
    end

endmodule

// File: tb/tb_jtcontra_obj_dma.sv
// ----------------------------------------------------------------------------
// tb_jtcontra_obj_dma
//   Self-checking bench for jtcontra_obj_dma. A frame-level model tracks which
//   table the renderer must see, when a copy is running and when the banks
//   exchange; a compare process checks every DUT output on every cycle.
//   Directed scenarios pin the model with literal expectations, then random
//   frames (random CPU writes, dma_en, vblank lengths incl. aborts) follow.
// ----------------------------------------------------------------------------
module tb_jtcontra_obj_dma;

    localparam int N = 320;

    logic clk = 1'b0;
    logic rst;
    logic LVBL;
    logic dma_en;
    logic busy;
    logic swap;

    jtcontra_obj_dma_if bus ();

    jtcontra_obj_dma #(.OBJ_BYTES(N), .AW(9)) dut (
        .clk    (clk),
        .rst    (rst),
        .LVBL   (LVBL),
        .dma_en (dma_en),
        .bus    (bus.master),
        .busy   (busy),
        .swap   (swap)
    );

    always #5 clk = ~clk;

    // ---------------- CPU object RAM (registered read) ----------------
    logic [7:0] src_mem [1024];
    always @(posedge clk) if (bus.src_cs) bus.src_data <= src_mem[bus.src_addr];

    // ---------------- bookkeeping ----------------
    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- frame-level reference model ----------------
    // A copy started at edge E reads byte k during the clk after edge E+k,
    // and the finished table becomes visible (swap) on edge E+N+1.
    int         cyc = 0;
    int         start_cyc = 0;
    bit         active = 0;
    bit         mfront = 0;
    bit         prev_lvbl = 1;
    bit         mvalid [2] = '{0, 0};
    logic [7:0] mbank [2][N];
    logic [7:0] snap [N];
    bit         model_ready = 0;
    bit         exp_busy, exp_swap, exp_cs, exp_obj_ok;
    logic [9:0] exp_addr;
    logic [7:0] exp_obj;

    always @(posedge clk) begin
        int off;
        cyc++;
        // renderer read uses the table shown before this edge
        if (rst) begin
            exp_obj_ok = 1;
            exp_obj    = 8'h00;
        end else begin
            exp_obj_ok = mvalid[mfront] && (bus.scan_addr[8:0] < 9'(N));
            exp_obj    = exp_obj_ok ? mbank[mfront][bus.scan_addr[8:0]] : 8'h00;
        end
        if (rst) begin
            active    = 0;
            mfront    = 0;
            prev_lvbl = 1;
            exp_swap  = 0;
        end else begin
            exp_swap = 0;
            if (active && LVBL) begin
                active = 0;
            end else if (active && (cyc - start_cyc == N + 1)) begin
                active = 0;
                for (int i = 0; i < N; i++) mbank[!mfront][i] = snap[i];
                mvalid[!mfront] = 1;
                mfront   = !mfront;
                exp_swap = 1;
            end
            if (!active && !LVBL && prev_lvbl && dma_en) begin
                active    = 1;
                start_cyc = cyc;
                for (int i = 0; i < N; i++) snap[i] = src_mem[i];
                mvalid[!mfront] = 0;
            end
            prev_lvbl = LVBL;
        end
        off      = cyc - start_cyc;
        exp_busy = active;
        exp_cs   = active && (off < N);
        exp_addr = exp_cs ? 10'(off) : 10'd0;
        model_ready = 1;
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (model_ready) begin
            check("busy",     32'(busy),         32'(exp_busy));
            check("swap",     32'(swap),         32'(exp_swap));
            check("src_cs",   32'(bus.src_cs),   32'(exp_cs));
            check("src_addr", 32'(bus.src_addr), 32'(exp_addr));
            if (exp_obj_ok) check("obj_scan", 32'(bus.obj_scan), 32'(exp_obj));
        end
    end

    // ---------------- stimulus helpers ----------------
    bit rand_scan = 0;
    always @(negedge clk) if (rand_scan) bus.scan_addr = 10'($urandom_range(0, N - 1));

    // Called right after a negedge; returns obj_scan one clk later.
    task automatic read_scan(input logic [9:0] a, output logic [7:0] d);
        rand_scan     = 0;
        bus.scan_addr = a;
        @(negedge clk);
        d         = bus.obj_scan;
        rand_scan = 1;
    endtask

    task automatic fill(input int mode, input logic [7:0] v);
        for (int i = 0; i < 1024; i++) begin
            logic [9:0] a;
            a = 10'(i);
            src_mem[i] = (mode == 0) ? (a[7:0] ^ 8'h5A) : v;
        end
    endtask

    // ---------------- main sequence ----------------
    initial begin
        logic [7:0] d;
        int busy_cnt, swap_cnt, swap_at, cs_cnt;
        rst = 1; LVBL = 1; dma_en = 0; bus.scan_addr = '0;
        fill(1, 8'h00);
        repeat (3) @(negedge clk);
        check("reset_busy",     32'(busy),         0);
        check("reset_swap",     32'(swap),         0);
        check("reset_src_cs",   32'(bus.src_cs),   0);
        check("reset_src_addr", 32'(bus.src_addr), 0);
        check("reset_obj_scan", 32'(bus.obj_scan), 0);
        check("reset_front",    32'(dut.front),    0);
        rst = 0; rand_scan = 1;
        repeat (10) @(negedge clk);

        // 1: full copy of addr^0x5A
        fill(0, 8'h00);
        dma_en = 1; LVBL = 0;
        busy_cnt = 0; swap_cnt = 0; swap_at = -1;
        for (int t = 1; t <= 400; t++) begin
            @(negedge clk);
            if (busy) busy_cnt++;
            if (swap) begin
                swap_cnt++;
                if (swap_at < 0) swap_at = t;
            end
        end
        check("t1_busy_clks", 32'(busy_cnt), 321);
        check("t1_swap_at",   32'(swap_at),  322);
        check("t1_swap_cnt",  32'(swap_cnt), 1);
        check("t1_front",     32'(dut.front), 1);
        read_scan(10'h13F, d);
        check("t1_scan_13F", 32'(d), 32'h65);
        LVBL = 1;
        repeat (20) @(negedge clk);

        // 2: vblank with dma_en=0
        dma_en = 0; LVBL = 0; cs_cnt = 0; swap_cnt = 0;
        repeat (50) begin
            @(negedge clk);
            if (bus.src_cs) cs_cnt++;
            if (swap) swap_cnt++;
        end
        LVBL = 1;
        @(negedge clk);
        check("t2_src_cs_cnt", 32'(cs_cnt), 0);
        check("t2_swap_cnt",   32'(swap_cnt), 0);
        read_scan(10'd5, d);
        check("t2_scan_5", 32'(d), 32'h5F);

        // 3: CPU rewrites during active video
        fill(1, 8'hC3);
        repeat (20) @(negedge clk);
        read_scan(10'd5, d);
        check("t3_scan_5", 32'(d), 32'h5F);
        read_scan(10'h13F, d);
        check("t3_scan_13F", 32'(d), 32'h65);

        // 4: abort 100 clks into a copy
        dma_en = 1; LVBL = 0;
        repeat (100) @(negedge clk);
        LVBL = 1;
        @(negedge clk);
        check("t4_busy",   32'(busy),       0);
        check("t4_src_cs", 32'(bus.src_cs), 0);
        check("t4_front",  32'(dut.front),  1);
        read_scan(10'h13F, d);
        check("t4_scan_13F", 32'(d), 32'h65);
        repeat (10) @(negedge clk);

        // 5: reset 50 clks into a copy, then two full frames 0x11 / 0x22
        fill(1, 8'h11);
        LVBL = 0;
        repeat (50) @(negedge clk);
        rst = 1; LVBL = 1;
        @(negedge clk);
        check("t5_busy",     32'(busy),         0);
        check("t5_src_cs",   32'(bus.src_cs),   0);
        check("t5_swap",     32'(swap),         0);
        check("t5_src_addr", 32'(bus.src_addr), 0);
        check("t5_obj_scan", 32'(bus.obj_scan), 0);
        check("t5_front",    32'(dut.front),    0);
        rst = 0;
        repeat (5) @(negedge clk);
        LVBL = 0;
        repeat (330) @(negedge clk);
        check("t6_front_a", 32'(dut.front), 1);
        read_scan(10'($urandom_range(0, N - 1)), d);
        check("t6_scan_11", 32'(d), 32'h11);
        LVBL = 1;
        repeat (20) @(negedge clk);
        fill(1, 8'h22);
        LVBL = 0;
        repeat (330) @(negedge clk);
        check("t6_front_b", 32'(dut.front), 0);
        read_scan(10'($urandom_range(0, N - 1)), d);
        check("t6_scan_22", 32'(d), 32'h22);
        LVBL = 1;

        // random frames: CPU writes in active video, random enable/vblank length
        for (int f = 0; f < 16; f++) begin
            int act_len, vb_len;
            act_len = $urandom_range(20, 150);
            repeat (act_len) begin
                @(negedge clk);
                src_mem[$urandom_range(0, N - 1)] = 8'($urandom);
            end
            dma_en = ($urandom_range(0, 3) != 0);
            vb_len = $urandom_range(5, 400);
            LVBL = 0;
            repeat (vb_len) begin
                @(negedge clk);
                if ($urandom_range(0, 15) == 0) dma_en = ~dma_en;
            end
            LVBL = 1;
        end
        repeat (10) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
